// File: rtl/veer_types.sv
// Shared types and constants for the fixed-latency divider and its writeback control.
package veer_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WB   = 2'd2
  } div_wb_state_t;

  // The divider wrapper uses this same value, so both ends agree on the latency.
  localparam int DIV_MBPTA_LATENCY = 33;
  localparam int DIV_CNT_W         = 6;

  function automatic logic [DIV_CNT_W-1:0] sat_inc(input logic [DIV_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/exu_div_lat_chk.sv
// Latency checker for one in-flight divide: saturating cycle counter plus the
// finish-time and timeout comparisons.
module exu_div_lat_chk
  import veer_types::*;
#(
  parameter int LATENCY = DIV_MBPTA_LATENCY,
  parameter int TIMEOUT = 48
) (
  input  logic clk,
  input  logic rst_l,
  input  logic start,
  input  logic run,
  input  logic finish,
  output logic on_time,
  output logic early_late,
  output logic timeout
);

  localparam logic [DIV_CNT_W-1:0] LAT_CNT = DIV_CNT_W'(LATENCY);
  localparam logic [DIV_CNT_W-1:0] TO_CNT  = DIV_CNT_W'(TIMEOUT);

  logic [DIV_CNT_W-1:0] cnt;

  // Counter reads k in the k-th cycle after issue; it returns to zero when the op ends.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= DIV_CNT_W'(1);
    end else if (run) begin
      cnt <= sat_inc(cnt);
    end else begin
      cnt <= '0;
    end
  end

  assign on_time    = finish & (cnt == LAT_CNT);
  assign early_late = finish & (cnt != LAT_CNT);
  assign timeout    = ~finish & (cnt == TO_CNT);

endmodule

// File: rtl/exu_div_wb_ctl.sv
// Divide writeback control: tracks one in-flight divide from issue to register-file
// writeback and flags any deviation from the fixed divider latency.
module exu_div_wb_ctl
  import veer_types::*;
#(
  parameter int DIV_LATENCY = DIV_MBPTA_LATENCY,
  parameter int TIMEOUT     = 48
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        scan_mode,
  input  logic        div_issue,
  input  logic [4:0]  div_rd,
  input  logic        flush_lower,
  input  logic        finish,
  input  logic [31:0] div_out,
  input  logic        wb_grant,
  output logic        busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        div_done,
  output logic        lat_err
);

  div_wb_state_t state, state_nxt;
  logic [4:0]    rd_q;
  logic [31:0]   data_q;
  logic          on_time, early_late, timeout;
  logic          fin_any, capture, lat_err_set, start, run;

  // scan_mode only matters for hand-instantiated flop cells; flops here are inferred.
  logic unused_scan_mode;
  assign unused_scan_mode = scan_mode;

  assign fin_any = on_time | early_late;
  assign start   = (state_nxt == BUSY) & (state != BUSY);
  assign run     = (state == BUSY) & (state_nxt == BUSY);

  exu_div_lat_chk #(
    .LATENCY (DIV_LATENCY),
    .TIMEOUT (TIMEOUT)
  ) u_lat_chk (
    .clk        (clk),
    .rst_l      (rst_l),
    .start      (start),
    .run        (run),
    .finish     (finish),
    .on_time    (on_time),
    .early_late (early_late),
    .timeout    (timeout)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Flush wins over finish in BUSY; once in WB the divide is architecturally done.
  always_comb begin
    state_nxt   = state;
    capture     = 1'b0;
    lat_err_set = 1'b0;
    case (state)
      IDLE: begin
        if (finish) lat_err_set = 1'b1;
        if (div_issue && !flush_lower) state_nxt = BUSY;
      end
      BUSY: begin
        if (div_issue) lat_err_set = 1'b1;
        if (flush_lower) begin
          state_nxt = IDLE;
        end else if (fin_any) begin
          capture   = 1'b1;
          state_nxt = (rd_q != 5'd0) ? WB : IDLE;
          if (early_late) lat_err_set = 1'b1;
        end else if (timeout) begin
          state_nxt   = IDLE;
          lat_err_set = 1'b1;
        end
      end
      WB: begin
        if (finish) lat_err_set = 1'b1;
        if (wb_grant) begin
          state_nxt = (div_issue && !flush_lower) ? BUSY : IDLE;
        end else if (div_issue) begin
          lat_err_set = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    wb_valid = 1'b0;
    wb_rd    = 5'd0;
    wb_data  = 32'd0;
    div_done = 1'b0;
    case (state)
      BUSY: div_done = capture & (rd_q == 5'd0);
      WB: begin
        wb_valid = 1'b1;
        wb_rd    = rd_q;
        wb_data  = data_q;
        div_done = wb_grant;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_q    <= 5'd0;
      data_q  <= 32'd0;
      lat_err <= 1'b0;
    end else begin
      if (start) rd_q <= div_rd;
      if (capture) data_q <= div_out;
      if (lat_err_set) lat_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_exu_div_wb_ctl.sv
// Directed self-checking bench for exu_div_wb_ctl: latency, flush, rd=0, back-to-back,
// early finish, timeout and asynchronous reset.
module tb_exu_div_wb_ctl;

  logic        clk;
  logic        rst_l;
  logic        scan_mode;
  logic        div_issue;
  logic [4:0]  div_rd;
  logic        flush_lower;
  logic        finish;
  logic [31:0] div_out;
  logic        wb_grant;
  logic        busy;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        div_done;
  logic        lat_err;

  int n_checks = 0;
  int n_pass   = 0;

  exu_div_wb_ctl dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .scan_mode   (scan_mode),
    .div_issue   (div_issue),
    .div_rd      (div_rd),
    .flush_lower (flush_lower),
    .finish      (finish),
    .div_out     (div_out),
    .wb_grant    (wb_grant),
    .busy        (busy),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .div_done    (div_done),
    .lat_err     (lat_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic iss, input logic [4:0] rd, input logic fl,
                               input logic fin, input logic [31:0] dout, input logic gnt);
    div_issue   = iss;
    div_rd      = rd;
    flush_lower = fl;
    finish      = fin;
    div_out     = dout;
    wb_grant    = gnt;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      idle();
      tick();
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    scan_mode = 1'b0;
    rst_l     = 1'b0;
    idle();
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_wb_valid", wb_valid, 1'b0);
    checkOutput("reset_wb_rd", wb_rd, 5'd0);
    checkOutput("reset_wb_data", wb_data, 32'd0);
    checkOutput("reset_lat_err", lat_err, 1'b0);
    @(negedge clk);
    rst_l = 1'b1;
    tick();

    $display("[TB] nominal divide rd=5");
    applyStimulus(1'b1, 5'd5, 1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("nom_busy_issue_cycle", busy, 1'b0);
    tick();
    idle();
    checkOutput("nom_busy_t1", busy, 1'b1);
    waitCycles(32);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 32'h0000_0007, 1'b0);
    checkOutput("nom_busy_t33", busy, 1'b1);
    checkOutput("nom_no_wb_t33", wb_valid, 1'b0);
    checkOutput("nom_no_done_t33", div_done, 1'b0);
    tick();
    idle();
    checkOutput("nom_wb_valid_t34", wb_valid, 1'b1);
    checkOutput("nom_wb_rd_t34", wb_rd, 5'd5);
    checkOutput("nom_wb_data_t34", wb_data, 32'h7);
    checkOutput("nom_no_done_t34", div_done, 1'b0);
    tick();
    idle();
    checkOutput("nom_wb_hold_t35", wb_data, 32'h7);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    checkOutput("nom_done_t36", div_done, 1'b1);
    tick();
    idle();
    checkOutput("nom_idle_t37", busy, 1'b0);
    checkOutput("nom_wb_off_t37", wb_valid, 1'b0);
    checkOutput("nom_wb_rd_zero_t37", wb_rd, 5'd0);
    checkOutput("nom_lat_err", lat_err, 1'b0);

    $display("[TB] flush at T+10");
    applyStimulus(1'b1, 5'd3, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();
    waitCycles(9);
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput("flush_busy_t10", busy, 1'b1);
    tick();
    idle();
    checkOutput("flush_idle_t11", busy, 1'b0);
    waitCycles(40);
    checkOutput("flush_no_wb", wb_valid, 1'b0);
    checkOutput("flush_no_timeout", lat_err, 1'b0);

    $display("[TB] flush coincident with finish");
    applyStimulus(1'b1, 5'd4, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();
    waitCycles(32);
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b1, 32'h55, 1'b0);
    checkOutput("flfin_no_done", div_done, 1'b0);
    tick();
    idle();
    checkOutput("flfin_idle", busy, 1'b0);
    checkOutput("flfin_no_wb", wb_valid, 1'b0);
    checkOutput("flfin_lat_err", lat_err, 1'b0);

    $display("[TB] rd=0 divide");
    applyStimulus(1'b1, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();
    waitCycles(32);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 32'h99, 1'b0);
    checkOutput("rd0_done_t33", div_done, 1'b1);
    checkOutput("rd0_no_wb_t33", wb_valid, 1'b0);
    tick();
    idle();
    checkOutput("rd0_idle_t34", busy, 1'b0);
    checkOutput("rd0_no_wb_t34", wb_valid, 1'b0);
    checkOutput("rd0_no_done_t34", div_done, 1'b0);

    $display("[TB] back-to-back grant and issue");
    applyStimulus(1'b1, 5'd6, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();
    waitCycles(32);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 32'h0000_AAAA, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd9, 1'b0, 1'b0, 32'd0, 1'b1);
    checkOutput("b2b_done", div_done, 1'b1);
    checkOutput("b2b_first_rd", wb_rd, 5'd6);
    checkOutput("b2b_first_data", wb_data, 32'h0000_AAAA);
    tick();
    idle();
    checkOutput("b2b_busy", busy, 1'b1);
    checkOutput("b2b_wb_off", wb_valid, 1'b0);
    waitCycles(32);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 32'h0000_1234, 1'b0);
    tick();
    idle();
    checkOutput("b2b_second_rd", wb_rd, 5'd9);
    checkOutput("b2b_second_data", wb_data, 32'h0000_1234);
    checkOutput("b2b_lat_err", lat_err, 1'b0);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    tick();
    idle();
    checkOutput("b2b_idle", busy, 1'b0);

    $display("[TB] early finish at T+20");
    applyStimulus(1'b1, 5'd7, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();
    waitCycles(19);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 32'h0000_DEAD, 1'b0);
    tick();
    idle();
    checkOutput("early_wb_valid", wb_valid, 1'b1);
    checkOutput("early_wb_rd", wb_rd, 5'd7);
    checkOutput("early_wb_data", wb_data, 32'h0000_DEAD);
    checkOutput("early_lat_err", lat_err, 1'b1);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    tick();
    applyStimulus(1'b1, 5'd1, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();
    waitCycles(32);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 32'h11, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    tick();
    idle();
    checkOutput("sticky_idle", busy, 1'b0);
    checkOutput("sticky_lat_err", lat_err, 1'b1);

    $display("[TB] async reset mid-busy");
    applyStimulus(1'b1, 5'd2, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();
    waitCycles(4);
    idle();
    checkOutput("arst_pre_busy", busy, 1'b1);
    #1;
    rst_l = 1'b0;
    #1;
    checkOutput("arst_busy", busy, 1'b0);
    checkOutput("arst_wb_valid", wb_valid, 1'b0);
    checkOutput("arst_lat_err", lat_err, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    tick();
    idle();
    checkOutput("arst_idle_after", busy, 1'b0);

    $display("[TB] missing finish timeout");
    applyStimulus(1'b1, 5'd8, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();
    waitCycles(47);
    idle();
    checkOutput("to_busy_t48", busy, 1'b1);
    checkOutput("to_no_err_t48", lat_err, 1'b0);
    tick();
    idle();
    checkOutput("to_idle_t49", busy, 1'b0);
    checkOutput("to_lat_err_t49", lat_err, 1'b1);
    checkOutput("to_no_wb_t49", wb_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
